eval_assert_window_monitor: RTL and testbench

- Parametrised multi-channel runtime assertion monitor; next generation of the single-shot "at least one of N signals high" checker.
- Each channel evaluates a configurable predicate over its term inputs every enabled cycle.
- A channel flags a violation only after WINDOW consecutive failing cycles.
- Failures are held in sticky status registers, with first-failure capture and a failure counter. These are readable by testbench or debug logic; it is instantiated alongside bus and pipeline interfaces in the eval testbench.

---
 rtl/eval_assert_pkg.sv | 23 ++
 rtl/eval_assert_chan.sv | 61 ++++++
 rtl/eval_assert_window_monitor.sv | 100 ++++++++++
 tb/tb_eval_assert_window_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eval_assert_pkg.sv
// Shared types and limits for the windowed assertion monitor.
// Predicate modes, size limits and the index-width helper live here.
package eval_assert_pkg;

  typedef enum logic [1:0] {
    MODE_ANY     = 2'd0,
    MODE_ONEHOT  = 2'd1,
    MODE_ATMOST1 = 2'd2
  } assert_mode_e;

  localparam int MAX_NCH    = 32;
  localparam int MAX_NTERM  = 16;
  localparam int MAX_WINDOW = 255;

  // Wide enough to hold a population count of MAX_NTERM terms.
  localparam int ONES_W = $clog2(MAX_NTERM + 1);

  // Width of a channel index; never below one bit so NCH=1 still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eval_assert_chan.sv
// One monitor channel: predicate over its terms, consecutive-failure run
// counter, and the fire strobe raised on the WINDOW-th failing cycle.
module eval_assert_chan
  import eval_assert_pkg::*;
#(
  parameter int NTERM  = 3,
  parameter int MODE   = 0,
  parameter int WINDOW = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [NTERM-1:0] terms,
  output logic             fire
);

  localparam int RUN_W = $clog2(WINDOW + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(WINDOW);
  localparam logic [RUN_W-1:0] RUN_FIRE = RUN_W'(WINDOW - 1);
  localparam assert_mode_e MODE_E = assert_mode_e'(MODE);

  logic [ONES_W-1:0] ones;
  logic              pred;
  logic              bad;
  logic [RUN_W-1:0]  run;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    ones = '0;
    for (int b = 0; b < NTERM; b++) begin
      ones = ones + ONES_W'(terms[b]);
    end
  end

  always_comb begin
    pred = 1'b1;
    case (MODE_E)
      MODE_ANY:     pred = |terms;
      MODE_ONEHOT:  pred = (ones == ONES_W'(1));
      MODE_ATMOST1: pred = (ones <= ONES_W'(1));
      default:      pred = 1'b1;
    endcase
  end

  assign bad  = en & ~pred;
  // Run saturates at WINDOW, so equality with WINDOW-1 can only hold once per failing run.
  assign fire = bad & (run == RUN_FIRE);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run <= '0;
    end else if (clear || !bad) begin
      run <= '0;
    end else if (run != RUN_MAX) begin
      run <= run + RUN_W'(1);
    end
  end

endmodule

// File: rtl/eval_assert_window_monitor.sv
// Multi-channel windowed assertion monitor: sticky status, first-failure capture,
// saturating fire counter. Optional EVAL_ASSERT_SIM_STOP_EN adds a sim-only report/stop.
module eval_assert_window_monitor
  import eval_assert_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int NTERM  = 3,
  parameter int MODE   = 0,
  parameter int WINDOW = 1,
  parameter int CNT_W  = 16,
  localparam int IDX_W = idx_width(NCH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clear,
  input  logic [NCH*NTERM-1:0] terms,
  output logic                 fail_pulse,
  output logic [NCH-1:0]       fail_sticky,
  output logic                 first_valid,
  output logic [IDX_W-1:0]     first_idx,
  output logic [CNT_W-1:0]     fail_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   fire;
  logic             any_fire;
  logic [IDX_W-1:0] low_idx;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    eval_assert_chan #(
      .NTERM  (NTERM),
      .MODE   (MODE),
      .WINDOW (WINDOW)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .clear (clear),
      .terms (terms[i*NTERM +: NTERM]),
      .fire  (fire[i])
    );
  end

  assign any_fire = |fire;

  // Scan from the top down so the lowest firing channel wins.
  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fire[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // Clear outranks a same-cycle fire: the event is dropped entirely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fail_pulse  <= 1'b0;
      fail_sticky <= '0;
      first_valid <= 1'b0;
      first_idx   <= '0;
      fail_count  <= '0;
    end else if (clear) begin
      fail_pulse  <= 1'b0;
      fail_sticky <= '0;
      first_valid <= 1'b0;
      first_idx   <= '0;
      fail_count  <= '0;
    end else begin
      fail_pulse  <= any_fire;
      fail_sticky <= fail_sticky | fire;
      if (any_fire && !first_valid) begin
        first_valid <= 1'b1;
        first_idx   <= low_idx;
      end
      if (any_fire && (fail_count != CNT_MAX)) begin
        fail_count <= fail_count + CNT_W'(1);
      end
    end
  end

`ifdef EVAL_ASSERT_SIM_STOP_EN
`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset && !clear) begin
      for (int i = 0; i < NCH; i++) begin
        if (fire[i]) begin
          $display("assert_window_monitor ch=%0d fail", i);
          $fatal(1);
        end
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_eval_assert_window_monitor.sv
// Bench for eval_assert_window_monitor: four differently configured instances share
// stimulus and are checked every cycle against a streak-based reference model.
module tb_eval_assert_window_monitor;

  localparam int ND = 4;
  localparam logic [11:0] IDLE = 12'b001_001_001_001;

  // Per-instance configuration mirrored by the model.
  int cfg_nch  [ND] = '{4, 4, 4, 3};
  int cfg_nterm[ND] = '{3, 3, 3, 2};
  int cfg_mode [ND] = '{0, 0, 1, 2};
  int cfg_win  [ND] = '{1, 3, 2, 2};
  int cfg_cmax [ND] = '{65535, 3, 65535, 15};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] terms = IDLE;

  logic        pulse_a, pulse_b, pulse_c, pulse_d;
  logic [3:0]  sticky_a, sticky_b, sticky_c;
  logic [2:0]  sticky_d;
  logic        fv_a, fv_b, fv_c, fv_d;
  logic [1:0]  idx_a, idx_b, idx_c, idx_d;
  logic [15:0] cnt_a, cnt_c;
  logic [1:0]  cnt_b;
  logic [3:0]  cnt_d;

  eval_assert_window_monitor #(.NCH(4), .NTERM(3), .MODE(0), .WINDOW(1), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .terms(terms[11:0]),
    .fail_pulse(pulse_a), .fail_sticky(sticky_a), .first_valid(fv_a),
    .first_idx(idx_a), .fail_count(cnt_a));

  eval_assert_window_monitor #(.NCH(4), .NTERM(3), .MODE(0), .WINDOW(3), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .terms(terms[11:0]),
    .fail_pulse(pulse_b), .fail_sticky(sticky_b), .first_valid(fv_b),
    .first_idx(idx_b), .fail_count(cnt_b));

  eval_assert_window_monitor #(.NCH(4), .NTERM(3), .MODE(1), .WINDOW(2), .CNT_W(16)) u_c (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .terms(terms[11:0]),
    .fail_pulse(pulse_c), .fail_sticky(sticky_c), .first_valid(fv_c),
    .first_idx(idx_c), .fail_count(cnt_c));

  eval_assert_window_monitor #(.NCH(3), .NTERM(2), .MODE(2), .WINDOW(2), .CNT_W(4)) u_d (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .terms(terms[5:0]),
    .fail_pulse(pulse_d), .fail_sticky(sticky_d), .first_valid(fv_d),
    .first_idx(idx_d), .fail_count(cnt_d));

  logic [31:0] o_pulse[ND], o_sticky[ND], o_fv[ND], o_idx[ND], o_cnt[ND];
  assign o_pulse  = '{32'(pulse_a),  32'(pulse_b),  32'(pulse_c),  32'(pulse_d)};
  assign o_sticky = '{32'(sticky_a), 32'(sticky_b), 32'(sticky_c), 32'(sticky_d)};
  assign o_fv     = '{32'(fv_a),     32'(fv_b),     32'(fv_c),     32'(fv_d)};
  assign o_idx    = '{32'(idx_a),    32'(idx_b),    32'(idx_c),    32'(idx_d)};
  assign o_cnt    = '{32'(cnt_a),    32'(cnt_b),    32'(cnt_c),    32'(cnt_d)};

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: consecutive failing-cycle streak per channel plus expected outputs.
  int m_streak[ND][4];
  int m_pulse[ND], m_sticky[ND], m_fv[ND], m_idx[ND], m_cnt[ND];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      for (int ch = 0; ch < 4; ch++) m_streak[k][ch] = 0;
      m_pulse[k] = 0; m_sticky[k] = 0; m_fv[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // A channel fires when its failing streak reaches exactly WINDOW cycles.
  task automatic model_step(input logic e, input logic c, input logic [11:0] t);
    for (int k = 0; k < ND; k++) begin
      int fires;
      int low;
      fires = 0;
      low = -1;
      for (int ch = 0; ch < cfg_nch[k]; ch++) begin
        int  ones;
        bit  ok;
        bit  bad;
        ones = 0;
        for (int b = 0; b < cfg_nterm[k]; b++) ones += int'(t[ch*cfg_nterm[k] + b]);
        case (cfg_mode[k])
          0:       ok = (ones > 0);
          1:       ok = (ones == 1);
          default: ok = (ones <= 1);
        endcase
        bad = e && !ok;
        m_streak[k][ch] = bad ? m_streak[k][ch] + 1 : 0;
        if (bad && m_streak[k][ch] == cfg_win[k]) begin
          fires |= (1 << ch);
          if (low < 0) low = ch;
        end
        if (c) m_streak[k][ch] = 0;
      end
      if (c) begin
        m_pulse[k] = 0; m_sticky[k] = 0; m_fv[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
      end else begin
        m_pulse[k]  = (fires != 0) ? 1 : 0;
        m_sticky[k] |= fires;
        if (m_fv[k] == 0 && fires != 0) begin
          m_fv[k]  = 1;
          m_idx[k] = low;
        end
        if (fires != 0 && m_cnt[k] < cfg_cmax[k]) m_cnt[k]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < ND; k++) begin
      check($sformatf("dut%0d.pulse", k),  o_pulse[k],  32'(m_pulse[k]));
      check($sformatf("dut%0d.sticky", k), o_sticky[k], 32'(m_sticky[k]));
      check($sformatf("dut%0d.fv", k),     o_fv[k],     32'(m_fv[k]));
      check($sformatf("dut%0d.idx", k),    o_idx[k],    32'(m_idx[k]));
      check($sformatf("dut%0d.count", k),  o_cnt[k],    32'(m_cnt[k]));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic cycle(input logic e, input logic c, input logic [11:0] t);
    en = e;
    clear = c;
    terms = t;
    @(posedge clock);
    model_step(e, c, t);
    #1;
    compare_all();
  endtask

  function automatic logic [11:0] with_chan(input logic [11:0] t, input int ch,
                                            input logic [2:0] v);
    logic [11:0] r;
    r = t;
    r[ch*3 +: 3] = v;
    return r;
  endfunction

  // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("async.count_b", 32'(cnt_b), 32'd0);
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] rt;
    model_reset();
    #2;
    reset = 1'b1;
    #1;
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
    en = 1'b1;

    // Single-cycle failure on ch2, immediate-fire instance.
    cycle(1'b1, 1'b0, with_chan(IDLE, 2, 3'b000));
    check("imm.pulse",  32'(pulse_a),  32'd1);
    check("imm.sticky", 32'(sticky_a), 32'b0100);
    check("imm.idx",    32'(idx_a),    32'd2);
    check("imm.count",  32'(cnt_a),    32'd1);
    cycle(1'b1, 1'b0, IDLE);
    check("imm.pulse_once", 32'(pulse_a), 32'd0);

    // Window of 3: short run ignored, long run fires once.
    cycle(1'b1, 1'b1, IDLE);
    repeat (2) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    cycle(1'b1, 1'b0, IDLE);
    repeat (5) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    cycle(1'b1, 1'b0, IDLE);
    check("win.count",  32'(cnt_b),    32'd1);
    check("win.sticky", 32'(sticky_b), 32'b0001);

    // Simultaneous ch1/ch3 fire, then a later ch0 fire.
    cycle(1'b1, 1'b1, IDLE);
    cycle(1'b1, 1'b0, with_chan(with_chan(IDLE, 1, 3'b000), 3, 3'b000));
    check("pair.idx",    32'(idx_a),    32'd1);
    check("pair.sticky", 32'(sticky_a), 32'b1010);
    check("pair.count",  32'(cnt_a),    32'd1);
    cycle(1'b1, 1'b0, IDLE);
    cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    check("late.idx",    32'(idx_a),    32'd1);
    check("late.sticky", 32'(sticky_a), 32'b1011);

    // Clear during a fire drops it; the window restarts from zero.
    cycle(1'b1, 1'b0, IDLE);
    cycle(1'b1, 1'b1, with_chan(IDLE, 0, 3'b000));
    check("clr.pulse",  32'(pulse_a),  32'd0);
    check("clr.sticky", 32'(sticky_a), 32'd0);
    check("clr.fv",     32'(fv_a),     32'd0);
    check("clr.count",  32'(cnt_a),    32'd0);
    repeat (2) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    check("clr.win_early", 32'(pulse_b), 32'd0);
    cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    check("clr.win_fire", 32'(pulse_b), 32'd1);

    // One-hot instance: two bits high fails, one bit high passes.
    cycle(1'b1, 1'b1, IDLE);
    repeat (2) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b110));
    check("onehot.pulse",  32'(pulse_c),  32'd1);
    check("onehot.sticky", 32'(sticky_c), 32'b0001);
    repeat (3) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b010));
    check("onehot.pass", 32'(pulse_c), 32'd0);

    // Disabled checking never fires and leaves no partial run behind.
    repeat (4) cycle(1'b0, 1'b0, 12'h000);
    check("en0.pulse", 32'(pulse_b), 32'd0);
    repeat (2) cycle(1'b1, 1'b0, 12'h000);
    check("en1.early", 32'(pulse_b), 32'd0);
    cycle(1'b1, 1'b0, 12'h000);
    check("en1.fire", 32'(pulse_b), 32'd1);
    cycle(1'b1, 1'b0, IDLE);

    // Two-bit counter saturates after five firing runs.
    cycle(1'b1, 1'b1, IDLE);
    repeat (5) begin
      repeat (3) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
      cycle(1'b1, 1'b0, IDLE);
    end
    check("sat.count", 32'(cnt_b), 32'd3);

    // Reset mid-window discards the partial run.
    repeat (2) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    async_reset();
    cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    check("rst.no_history", 32'(pulse_b), 32'd0);
    repeat (2) cycle(1'b1, 1'b0, with_chan(IDLE, 0, 3'b000));
    check("rst.refire", 32'(pulse_b), 32'd1);

    // Randomized phase: faults persist for several cycles so windows can complete.
    rt = IDLE;
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) rt = 12'($urandom());
      else if ($urandom_range(0, 7) == 0) rt = IDLE;
      cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 49) == 0), rt);
    end
    async_reset();
    cycle(1'b1, 1'b0, IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
